// File: rtl/leaf_router.sv
// leaf_router: single-flit leaf switch (4 GPU leaf ports + 1 spine uplink) for one Dragonfly+ group.
// Latency: 1 cycle from FIFO write to output register when uncontested; one flit per output per cycle.
// Backpressure: per-input ready = FIFO not full; local outputs have none, uplink output holds until up_ready_in.
//
// Ports:
//   clk, reset (async, active-low)
//   loc_data_in/loc_valid_in/loc_ready_out  : 4 packed leaf inputs, port i at [i*DATA_W +: DATA_W]
//   loc_data_out/loc_valid_out              : 4 packed leaf outputs, one-cycle valid pulse per flit
//   up_data_in/up_valid_in/up_ready_out     : uplink input
//   up_data_out/up_valid_out/up_ready_in    : uplink output, valid/ready handshake
//   drop_count                              : only when LEAF_DROP_CNT_EN is defined; counts
//                                             foreign-group flits discarded from the uplink, saturating
//
// Header: [DATA_W-1 -: 4] group, [DATA_W-5 -: 2] leaf. Flits are forwarded unmodified.

module leaf_router #(
  parameter int DATA_W     = 16,
  parameter int GROUP_ID   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DATA_W-1:0] loc_data_in,
  input  logic [3:0]          loc_valid_in,
  output logic [3:0]          loc_ready_out,
  output logic [4*DATA_W-1:0] loc_data_out,
  output logic [3:0]          loc_valid_out,
  input  logic [DATA_W-1:0]   up_data_in,
  input  logic                up_valid_in,
  output logic                up_ready_out,
  output logic [DATA_W-1:0]   up_data_out,
  output logic                up_valid_out,
  input  logic                up_ready_in
`ifdef LEAF_DROP_CNT_EN
  ,
  output logic [7:0]          drop_count
`endif
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam int         NI      = 5;
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [3:0] GID     = GROUP_ID[3:0];
  localparam logic [2:0] UP      = 3'd4;

  // Modulo-5 add for round-robin indices (both operands are < 5).
  function automatic logic [2:0] wrap5(input logic [2:0] a, input logic [2:0] b);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  logic [DATA_W-1:0] in_dat   [NI];
  logic [NI-1:0]     in_vld;
  logic [DATA_W-1:0] mem      [NI][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr   [NI];
  logic [AW-1:0]     rd_ptr   [NI];
  logic [AW:0]       cnt      [NI];
  logic [NI-1:0]     rdy, push, pop, nonempty, discard;
  logic [DATA_W-1:0] head     [NI];
  logic [2:0]        dest     [NI];
  logic [2:0]        rr_ptr   [NI];
  logic [NI-1:0]     gnt_vld;
  logic [2:0]        gnt_src  [NI];
  logic [2:0]        sel;
  logic              up_gate;
  logic [DATA_W-1:0] loc_dat_q [4];

  // Input unpacking, FIFO status and route decode of each head.
  always_comb begin
    for (int i = 0; i < 4; i++) in_dat[i] = loc_data_in[i*DATA_W +: DATA_W];
    in_dat[4] = up_data_in;
    in_vld    = {up_valid_in, loc_valid_in};
    discard   = '0;
    for (int i = 0; i < NI; i++) begin
      rdy[i]      = cnt[i] < DEPTH_C;
      push[i]     = in_vld[i] && rdy[i];
      nonempty[i] = cnt[i] != '0;
      head[i]     = mem[i][rd_ptr[i]];
      if (head[i][DATA_W-1 -: 4] == GID) dest[i] = {1'b0, head[i][DATA_W-5 -: 2]};
      else                               dest[i] = UP;
    end
    // A foreign flit arriving from the spine has nowhere to go: drop it at the head.
    discard[4] = nonempty[4] && (dest[4] == UP);
  end

  assign loc_ready_out = rdy[3:0];
  assign up_ready_out  = rdy[4];

  // The uplink register may only be reloaded when empty or being accepted this cycle.
  assign up_gate = !up_valid_out || up_ready_in;

  // Per-output round-robin search starting at rr_ptr. Each head names exactly one
  // output, so an input can never be granted twice in a cycle.
  always_comb begin
    pop     = discard;
    gnt_vld = '0;
    sel     = '0;
    for (int o = 0; o < NI; o++) begin
      gnt_src[o] = '0;
      if (o != NI - 1 || up_gate) begin
        for (int k = 0; k < NI; k++) begin
          sel = wrap5(rr_ptr[o], 3'(k));
          if (!gnt_vld[o] && nonempty[sel] && !discard[sel] && dest[sel] == 3'(o)) begin
            gnt_vld[o] = 1'b1;
            gnt_src[o] = sel;
          end
        end
      end
      if (gnt_vld[o]) pop[gnt_src[o]] = 1'b1;
    end
  end

  // FIFO storage has no reset: occupancy is tracked solely by the pointers/count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NI; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= in_dat[i];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Output registers and round-robin pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loc_valid_out <= '0;
      up_valid_out  <= 1'b0;
      up_data_out   <= '0;
      for (int o = 0; o < 4; o++)  loc_dat_q[o] <= '0;
      for (int o = 0; o < NI; o++) rr_ptr[o] <= '0;
    end else begin
      for (int o = 0; o < 4; o++) begin
        loc_valid_out[o] <= gnt_vld[o];
        if (gnt_vld[o]) loc_dat_q[o] <= head[gnt_src[o]];
      end
      if (gnt_vld[4]) begin
        up_valid_out <= 1'b1;
        up_data_out  <= head[gnt_src[4]];
      end else if (up_ready_in) begin
        up_valid_out <= 1'b0;
      end
      for (int o = 0; o < NI; o++)
        if (gnt_vld[o]) rr_ptr[o] <= wrap5(gnt_src[o], 3'd1);
    end
  end

  always_comb begin
    for (int o = 0; o < 4; o++) loc_data_out[o*DATA_W +: DATA_W] = loc_dat_q[o];
  end

`ifdef LEAF_DROP_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                drop_count <= '0;
    else if (discard[4] && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_leaf_router.sv
// tb_leaf_router: directed test-plan steps followed by random traffic, all checked
// against a queue-based reference model of the switch (GROUP_ID=1, depth 4).
// Inputs change on the falling edge; outputs are compared on the falling edge.

module tb_leaf_router;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*DW-1:0] loc_data_in;
  logic [3:0]    loc_valid_in;
  logic [3:0]    loc_ready_out;
  logic [4*DW-1:0] loc_data_out;
  logic [3:0]    loc_valid_out;
  logic [DW-1:0] up_data_in;
  logic          up_valid_in;
  logic          up_ready_out;
  logic [DW-1:0] up_data_out;
  logic          up_valid_out;
  logic          up_ready_in;
`ifdef LEAF_DROP_CNT_EN
  logic [7:0]    drop_count;
`endif

  always #5 clk = ~clk;

  leaf_router #(.DATA_W(DW), .GROUP_ID(1), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .loc_data_in   (loc_data_in),
    .loc_valid_in  (loc_valid_in),
    .loc_ready_out (loc_ready_out),
    .loc_data_out  (loc_data_out),
    .loc_valid_out (loc_valid_out),
    .up_data_in    (up_data_in),
    .up_valid_in   (up_valid_in),
    .up_ready_out  (up_ready_out),
    .up_data_out   (up_data_out),
    .up_valid_out  (up_valid_out),
    .up_ready_in   (up_ready_in)
`ifdef LEAF_DROP_CNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one queue per input, a round-robin pointer per output,
  // and the visible output registers.
  logic [15:0] mq [5][$];
  int          rr [5];
  logic [3:0]  m_lvld;
  logic [15:0] m_ldat [4];
  logic        m_uvld;
  logic [15:0] m_udat;
  int          m_drop;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      mq[i].delete();
      rr[i] = 0;
    end
    for (int o = 0; o < 4; o++) m_ldat[o] = 16'h0;
    m_lvld = 4'h0;
    m_uvld = 1'b0;
    m_udat = 16'h0;
    m_drop = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int          dst [5];
    int          win [5];
    bit          acc [5];
    bit          disc;
    logic [15:0] h;
    disc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      acc[i] = mq[i].size() < 4;
      dst[i] = -1;
      if (mq[i].size() > 0) begin
        h = mq[i][0];
        if (h[15:12] == 4'd1) dst[i] = int'(h[11:10]);
        else if (i == 4)      disc = 1'b1;
        else                  dst[i] = 4;
      end
    end
    for (int o = 0; o < 5; o++) begin
      win[o] = -1;
      if (o < 4 || !m_uvld || up_ready_in)
        for (int k = 0; k < 5; k++)
          if (win[o] < 0 && dst[(rr[o] + k) % 5] == o) win[o] = (rr[o] + k) % 5;
    end
    for (int o = 0; o < 4; o++) begin
      m_lvld[o] = win[o] >= 0;
      if (win[o] >= 0) m_ldat[o] = mq[win[o]][0];
    end
    if (win[4] >= 0) begin
      m_uvld = 1'b1;
      m_udat = mq[win[4]][0];
    end else if (up_ready_in) begin
      m_uvld = 1'b0;
    end
    for (int o = 0; o < 5; o++)
      if (win[o] >= 0) begin
        void'(mq[win[o]].pop_front());
        rr[o] = (win[o] + 1) % 5;
      end
    if (disc) begin
      void'(mq[4].pop_front());
      if (m_drop < 255) m_drop++;
    end
    for (int i = 0; i < 4; i++)
      if (loc_valid_in[i] && acc[i]) mq[i].push_back(loc_data_in[i*16 +: 16]);
    if (up_valid_in && acc[4]) mq[4].push_back(up_data_in);
  endtask

  // One clock: check readies, step model, clock, check outputs.
  task automatic cyc();
    for (int i = 0; i < 4; i++)
      chk($sformatf("loc_ready%0d", i), loc_ready_out[i], mq[i].size() < 4);
    chk("up_ready", up_ready_out, mq[4].size() < 4);
    model_step();
    @(posedge clk);
    @(negedge clk);
    chk("loc_valid", loc_valid_out, m_lvld);
    for (int o = 0; o < 4; o++)
      if (m_lvld[o]) chk($sformatf("loc_data%0d", o), loc_data_out[o*16 +: 16], m_ldat[o]);
    chk("up_valid", up_valid_out, m_uvld);
    if (m_uvld) chk("up_data", up_data_out, m_udat);
`ifdef LEAF_DROP_CNT_EN
    chk("drop_count", drop_count, m_drop);
`endif
  endtask

  task automatic idle();
    loc_valid_in = 4'h0;
    up_valid_in  = 1'b0;
  endtask

  function automatic logic [15:0] rnd_flit();
    logic [3:0] g;
    g = ($urandom_range(0, 1) == 0) ? 4'd1 : 4'($urandom_range(0, 15));
    return {g, 2'($urandom_range(0, 3)), 10'($urandom_range(0, 1023))};
  endfunction

  initial begin
    reset        = 1'b0;
    loc_data_in  = '0;
    up_data_in   = '0;
    idle();
    up_ready_in  = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_loc_valid", loc_valid_out, 4'h0);
    chk("rst_loc_data",  loc_data_out, 64'h0);
    chk("rst_up_valid",  up_valid_out, 1'b0);
    chk("rst_up_data",   up_data_out, 16'h0);
    chk("rst_loc_ready", loc_ready_out, 4'hF);
    chk("rst_up_ready",  up_ready_out, 1'b1);
`ifdef LEAF_DROP_CNT_EN
    chk("rst_drop", drop_count, 8'd0);
`endif
    reset = 1'b1;
    cyc();

    // Local routing: port 0 -> leaf 1
    loc_data_in[15:0] = 16'h1402;
    loc_valid_in      = 4'b0001;
    cyc();
    idle();
    cyc();
    chk("t1_valid", loc_valid_out, 4'b0010);
    chk("t1_data",  loc_data_out[31:16], 16'h1402);
    chk("t1_up",    up_valid_out, 1'b0);
    cyc();
    chk("t1_pulse", loc_valid_out, 4'b0000);

    // Contention: four ports, four flits each, all to leaf 3
    for (int t = 0; t < 18; t++) begin
      if (t < 4) begin
        loc_valid_in = 4'hF;
        for (int p = 0; p < 4; p++)
          loc_data_in[p*16 +: 16] = 16'h1C00 | 16'(p << 4) | 16'(t);
      end else begin
        idle();
      end
      cyc();
      if (t >= 1 && t <= 16) begin
        chk("cont_vld", loc_valid_out[3], 1'b1);
        chk("cont_dat", loc_data_out[63:48], 16'h1C00 | 16'(((t - 1) % 4) << 4) | 16'((t - 1) / 4));
      end
    end
    chk("cont_end", loc_valid_out[3], 1'b0);

    // Foreign group to uplink with 3 stalled cycles
    up_ready_in        = 1'b0;
    loc_data_in[47:32] = 16'h2C05;
    loc_valid_in       = 4'b0100;
    cyc();
    idle();
    for (int s = 0; s < 3; s++) begin
      cyc();
      chk("fg_hold_vld", up_valid_out, 1'b1);
      chk("fg_hold_dat", up_data_out, 16'h2C05);
    end
    up_ready_in = 1'b1;
    cyc();
    chk("fg_done", up_valid_out, 1'b0);

    // Backpressure: 5 flits from port 1 to a foreign group, uplink stalled
    up_ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      loc_data_in[31:16] = 16'h2000 | 16'(k);
      loc_valid_in       = 4'b0010;
      cyc();
    end
    idle();
    chk("bp_full", loc_ready_out[1], 1'b0);
    cyc();
    chk("bp_still_full", loc_ready_out[1], 1'b0);
    up_ready_in = 1'b1;
    cyc();
    chk("bp_recover", loc_ready_out[1], 1'b1);
    chk("bp_next", up_data_out, 16'h2001);
    repeat (6) cyc();

    // Uplink drop of a foreign-group flit
    up_data_in  = 16'h3000;
    up_valid_in = 1'b1;
    cyc();
    idle();
    cyc();
    chk("drop_novalid", {up_valid_out, loc_valid_out}, 5'h0);
`ifdef LEAF_DROP_CNT_EN
    chk("drop_one", drop_count, 8'd1);
`endif
    for (int k = 0; k < 300; k++) begin
      up_data_in  = 16'h3000 | 16'(k & 16'h3FF);
      up_valid_in = 1'b1;
      cyc();
    end
    idle();
    repeat (2) cyc();
`ifdef LEAF_DROP_CNT_EN
    chk("drop_sat", drop_count, 8'd255);
`endif

    // Reset mid-stream: one flit held on the uplink, three buffered
    up_ready_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      loc_data_in[15:0] = 16'h2100 | 16'(k);
      loc_valid_in      = 4'b0001;
      cyc();
    end
    idle();
    reset = 1'b0;
    #1;
    chk("mrst_valids", {up_valid_out, loc_valid_out}, 5'h0);
    chk("mrst_readys", {up_ready_out, loc_ready_out}, 5'h1F);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset       = 1'b1;
    up_ready_in = 1'b1;
    repeat (4) cyc();
    chk("mrst_nostale", {up_valid_out, loc_valid_out}, 5'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 4; p++) loc_data_in[p*16 +: 16] = rnd_flit();
      up_data_in   = rnd_flit();
      loc_valid_in = 4'($urandom_range(0, 15));
      up_valid_in  = 1'($urandom_range(0, 1));
      up_ready_in  = $urandom_range(0, 3) != 0;
      cyc();
    end
    idle();
    up_ready_in = 1'b1;
    repeat (30) cyc();
    chk("drain_idle", {up_valid_out, loc_valid_out}, 5'h0);
    chk("drain_ready", {up_ready_out, loc_ready_out}, 5'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
